// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap or one-shot mode, a one-cycle terminal-count tick and a done level.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_clamp;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;
  logic             w_hit;

  // Terminal target and the modulo-(MAX_VAL+1) successor in the current direction
  always_comb begin
    w_term       = up_dn ? TOP : ZERO;
    w_load_clamp = (load_val > TOP) ? TOP : load_val;
    if (up_dn) begin
      if (r_count >= TOP) begin
        w_step = mode ? TOP : ZERO;
      end else begin
        w_step = r_count + ONE;
      end
    end else begin
      if (r_count == ZERO) begin
        w_step = mode ? ZERO : TOP;
      end else begin
        w_step = r_count - ONE;
      end
    end
    w_hit = (w_step == w_term);
  end

  // Priority: load > done-hold > enabled step > hold
  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    if (load) begin
      w_count_nxt = w_load_clamp;
      w_done_nxt  = 1'b0;
    end else if (r_done) begin
      // Leaving one-shot releases the hold; counting resumes on the next enabled edge
      if (!mode) begin
        w_done_nxt = 1'b0;
      end
    end else if (en) begin
      w_count_nxt = w_step;
      w_tc_nxt    = w_hit;
      w_done_nxt  = mode & w_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= RST_CNT;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign done  = r_done;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed vector bench for param_updown_counter (WIDTH=4, MAX_VAL=9, RESET_VAL=0).
module tb_param_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       up_dn;
  logic       mode;
  logic [3:0] count;
  logic       tc;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic       mode;
    logic [3:0] c;
    logic       tc;
    logic       done;
    string      name;
  } vec_t;

  vec_t vecs[$];

  param_updown_counter #(
    .WIDTH(4),
    .MAX_VAL(9),
    .RESET_VAL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .load_val(load_val),
    .up_dn(up_dn),
    .mode(mode),
    .count(count),
    .tc(tc),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic ld, input logic [3:0] lv, input logic e,
                              input logic u, input logic m, input logic [3:0] c,
                              input logic t, input logic d, input string name);
    vec_t v;
    v.load = ld; v.lv = lv; v.en = e; v.up = u; v.mode = m;
    v.c = c; v.tc = t; v.done = d; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] c, input logic t, input logic d);
    checks++;
    if (count !== c) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, count, c);
    end
    checks++;
    if (tc !== t) begin
      errors++;
      $display("FAIL %s tc: got %b expected %b", name, tc, t);
    end
    checks++;
    if (done !== d) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, done, d);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] lv, input logic e,
                       input logic u, input logic m);
    load = ld; load_val = lv; en = e; up_dn = u; mode = m;
  endtask

  initial begin
    // Down wrap, mode 0
    add(1, 2,  0, 0, 0, 2, 0, 0, "dn_load2");
    add(0, 0,  1, 0, 0, 1, 0, 0, "dn_1");
    add(0, 0,  1, 0, 0, 0, 1, 0, "dn_0_tc");
    add(0, 0,  1, 0, 0, 9, 0, 0, "dn_wrap9");
    add(0, 0,  1, 0, 0, 8, 0, 0, "dn_8");
    // Up wrap over modulus 10
    add(1, 8,  0, 1, 0, 8, 0, 0, "up_load8");
    add(0, 0,  1, 1, 0, 9, 1, 0, "up_9_tc");
    add(0, 0,  1, 1, 0, 0, 0, 0, "up_wrap0");
    add(0, 0,  1, 1, 0, 1, 0, 0, "up_1");
    // One-shot down, then reload
    add(1, 3,  1, 0, 1, 3, 0, 0, "os_load3");
    add(0, 0,  1, 0, 1, 2, 0, 0, "os_2");
    add(0, 0,  1, 0, 1, 1, 0, 0, "os_1");
    add(0, 0,  1, 0, 1, 0, 1, 1, "os_0_done");
    add(0, 0,  1, 0, 1, 0, 0, 1, "os_hold_a");
    add(0, 0,  1, 0, 1, 0, 0, 1, "os_hold_b");
    add(1, 5,  1, 0, 1, 5, 0, 0, "os_reload5");
    add(0, 0,  1, 0, 1, 4, 0, 0, "os_4");
    add(0, 0,  1, 0, 1, 3, 0, 0, "os_3");
    // Load clamp and load-over-enable priority
    add(1, 15, 1, 1, 0, 9, 0, 0, "clamp15");
    add(0, 0,  1, 0, 0, 8, 0, 0, "clamp_then_8");
    // One-shot up to done, release via mode 0, direction switch
    add(1, 7,  0, 1, 1, 7, 0, 0, "dir_load7");
    add(0, 0,  1, 1, 1, 8, 0, 0, "dir_8");
    add(0, 0,  1, 1, 1, 9, 1, 1, "dir_9_done");
    add(0, 0,  1, 1, 1, 9, 0, 1, "dir_done_hold");
    add(0, 0,  1, 1, 0, 9, 0, 0, "dir_release");
    add(0, 0,  1, 1, 0, 0, 0, 0, "dir_wrap0");
    add(0, 0,  1, 1, 0, 1, 0, 0, "dir_1");
    add(0, 0,  1, 1, 0, 2, 0, 0, "dir_2");
    add(0, 0,  1, 1, 0, 3, 0, 0, "dir_3");
    add(0, 0,  1, 1, 0, 4, 0, 0, "dir_4");
    add(0, 0,  1, 0, 0, 3, 0, 0, "dir_sw_3");
    add(0, 0,  1, 0, 0, 2, 0, 0, "dir_sw_2");
    add(0, 0,  0, 0, 0, 2, 0, 0, "en0_hold");
    // Load onto terminal gives no tc; switch onto new terminal gives no tc
    add(1, 0,  1, 0, 0, 0, 0, 0, "load_on_T");
    add(0, 0,  1, 0, 0, 9, 0, 0, "wrap_no_tc");
    add(0, 0,  0, 1, 0, 9, 0, 0, "retarget_hold");
    add(0, 0,  1, 1, 0, 0, 0, 0, "retarget_wrap");

    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("reset_init", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].mode);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].c, vecs[i].tc, vecs[i].done);
    end

    // Asynchronous reset with tc and done both set
    drive(1, 8, 0, 1, 1);
    @(posedge clk); #1;
    check("ar_load8", 4'd8, 1'b0, 1'b0);
    drive(0, 0, 1, 1, 1);
    @(posedge clk); #1;
    check("ar_9_done", 4'd9, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_async", 4'd0, 1'b0, 1'b0);
    drive(1, 6, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("ar_held", 4'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("ar_resume", 4'd1, 1'b0, 1'b0);

    // Count at 6 then reset between edges
    drive(1, 5, 0, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 0);
    @(posedge clk); #1;
    check("ar2_6", 4'd6, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("ar2_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
